// File: rtl/reg_native_pkg.sv
// Shared definitions for reg_native_if initiators and the regslv register slave.
package reg_native_pkg;

  localparam int REG_ADDR_WIDTH = 64;
  localparam int REG_DATA_WIDTH = 32;

  localparam logic RSP_OK      = 1'b0;
  localparam logic RSP_TIMEOUT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    RSP  = 2'd3
  } state_t;

endpackage

// File: rtl/reg_native_master.sv
// Converts one valid/ready read or write command into a single reg_native_if
// transaction, with a per-transaction timeout so every command gets a response.
module reg_native_master
  import reg_native_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  // Every channel here (cmd, rsp, req, ack) transfers on a cycle where valid
  // and ready are both high at the rising edge; valid never waits on ready.
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  req_vld,
  input  logic                  req_rdy,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  ack_vld,
  output logic                  ack_rdy,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            state_dbg
);

  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam int              CNT_W   = TO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cmd_fire, req_fire, ack_fire, busy, expired, enter_rsp;

  always_comb begin
    state_d   = state_q;
    cmd_fire  = (state_q == IDLE) && cmd_vld;
    req_fire  = (state_q == REQ) && req_rdy;
    ack_fire  = (state_q == ACK) && ack_vld;
    busy      = (state_q == REQ) || (state_q == ACK);
    expired   = TO_EN && busy && (cnt_q == CNT_MAX);
    cmd_rdy   = (state_q == IDLE);
    req_vld   = (state_q == REQ);
    ack_rdy   = (state_q == ACK);
    rsp_vld   = (state_q == RSP);
    state_dbg = state_q;
    // A handshake in the expiry cycle takes priority over the abort.
    case (state_q)
      IDLE: if (cmd_fire) state_d = REQ;
      REQ: begin
        if (req_fire)     state_d = ACK;
        else if (expired) state_d = RSP;
      end
      ACK: begin
        if (ack_fire)     state_d = RSP;
        else if (expired) state_d = RSP;
      end
      RSP: if (rsp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    enter_rsp = (state_d == RSP) && (state_q != RSP);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      addr      <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (cmd_fire) begin
        addr    <= cmd_addr;
        wr_data <= cmd_wdata;
        wr_en   <= cmd_wr;
        rd_en   <= !cmd_wr;
        cnt_q   <= '0;
      end else if (TO_EN && busy && (cnt_q != CNT_MAX)) begin
        // Saturates so a late REQ handshake still leaves a bounded ACK phase.
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (enter_rsp) begin
        wr_en     <= 1'b0;
        rd_en     <= 1'b0;
        rsp_err   <= ack_fire ? RSP_OK : RSP_TIMEOUT;
        rsp_rdata <= (ack_fire && rd_en) ? rd_data : '0;
      end
    end
  end

endmodule
